display_scan_controller: RTL and testbench

- Time-multiplexes NUM_DIGITS hex digits onto one shared seven-segment decoder and one segment bus, driving a one-hot digit enable.
- Double-buffers the displayed value so a frame is never torn.
- Inserts a guard (all-off) interval between digits to suppress ghosting.
- Sits between the system register holding a hex value and the board's segment/digit pins.

---
 rtl/display_pkg.sv | 28 ++
 rtl/seven_segments.sv | 34 +++
 rtl/display_scan_controller.sv | 182 ++++++++++++++++++
 tb/tb_display_scan_controller.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment display path.
//
// Contents:
//   scan_state_t  - scan controller states (IDLE, DRIVE, GUARD)
//   SEG_OFF       - all segments dark
//   MAX_DIGITS    - widest digit count the helpers support
//   onehot()      - digit index to one-hot digit enable
package display_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GUARD
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Bit idx set, all others clear. Callers narrow the result to their digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] result;
    result      = '0;
    result[idx] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/seven_segments.sv
// Hex nibble to seven-segment pattern decoder (purely combinational).
//
// Ports:
//   hex  in   4  nibble to display (0..F)
//   seg  out  7  active-high segments, bit6 = a ... bit0 = g
// Letters b and d use lowercase glyphs so they stay distinct from 8 and 0.
module seven_segments (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    unique case (hex)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed seven-segment scan controller.
//
// Drives NUM_DIGITS hex digits through one shared decoder and segment bus. Each digit is lit
// for REFRESH_DIV cycles followed by GUARD_CYCLES all-off cycles. The displayed value is
// double-buffered: load writes a shadow copy, which is promoted to the active copy only at a
// frame boundary (or when scanning starts), so a frame never mixes two values.
//
// Ports:
//   clk         in   1             system clock
//   rst_n       in   1             asynchronous active-low reset
//   enable      in   1             scan enable (a running frame always completes)
//   load        in   1             strobe: capture value into the shadow buffer
//   value       in   4*NUM_DIGITS  hex nibbles, digit i = value[4i+3:4i]
//   blank_mask  in   NUM_DIGITS    1 = digit i forced dark
//   digit_en    out  NUM_DIGITS    one-hot active-high digit enable
//   seg         out  7             active-high segments, bit6 = a ... bit0 = g
//   frame_done  out  1             one-cycle pulse after the last digit of a frame
//
// All outputs are registered from next-state values, so no input reaches an output
// combinationally.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;

  logic [NUM_DIGITS-1:0]   digit_en_d;
  logic [6:0]              seg_d;
  logic                    frame_done_d;

  logic                    advance;
  logic                    commit;
  logic [3:0]              nibble;
  logic [6:0]              seg_dec;
  logic                    drive_on;

  // Next-state logic for the scan FSM and the display buffers.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;
    advance      = 1'b0;
    commit       = 1'b0;

    if (load) begin
      shadow_d  = value;
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          commit  = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          cnt_d = '0;
          if (GUARD_CYCLES == 0) begin
            advance = 1'b1;
          end else begin
            state_d = GUARD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      cnt_d = '0;
      if (idx_q != IDX_LAST) begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = DRIVE;
      end else begin
        // Frame end: only here may the active buffer change while scanning.
        idx_d        = '0;
        frame_done_d = 1'b1;
        commit       = 1'b1;
        state_d      = enable ? DRIVE : IDLE;
      end
    end

    // A load on the commit edge goes straight to the active buffer so it is not held back a
    // whole frame behind the shadow copy.
    if (commit) begin
      if (load) begin
        active_d  = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // The decoder sees next-state idx/active so seg lines up with digit_en on the same edge.
  assign nibble = active_d[{idx_d, 2'b00} +: 4];

  seven_segments u_decoder (
    .hex (nibble),
    .seg (seg_dec)
  );

  assign drive_on = (state_d == DRIVE) && !blank_mask[idx_d];

  always_comb begin
    digit_en_d = '0;
    seg_d      = SEG_OFF;
    if (drive_on) begin
      digit_en_d = NUM_DIGITS'(onehot(3'(idx_d)));
      seg_d      = seg_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      pending_q  <= 1'b0;
      digit_en   <= '0;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      digit_en   <= digit_en_d;
      seg        <= seg_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (guard of 1 cycle and no guard) share the
// stimulus. A frame-position reference model predicts every output cycle into a queue per
// instance; a negedge monitor pops and compares.
module tb_display_scan_controller;

  localparam int N = 4;
  localparam int R = 4;

  typedef struct packed {
    logic [3:0] de;
    logic [6:0] sg;
    logic       fd;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  blank_mask = '0;

  logic [3:0] de_g1, de_g0;
  logic [6:0] sg_g1, sg_g0;
  logic       fd_g1, fd_g0;

  int checks = 0;
  int failures = 0;

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  bit          m_run[2];
  int          m_pos[2];
  logic [15:0] m_shadow[2];
  logic [15:0] m_active[2];
  bit          m_pend[2];

  logic [6:0] seg_tab[16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  display_scan_controller #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (1)
  ) u_dut_g1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .digit_en   (de_g1),
    .seg        (sg_g1),
    .frame_done (fd_g1)
  );

  display_scan_controller #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .GUARD_CYCLES (0)
  ) u_dut_g0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .digit_en   (de_g0),
    .seg        (sg_g0),
    .frame_done (fd_g0)
  );

  always #5 clk = ~clk;

  function automatic int glen(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  function automatic int flen(input int k);
    return N * (R + glen(k));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k]    = 1'b0;
      m_pos[k]    = 0;
      m_shadow[k] = '0;
      m_active[k] = '0;
      m_pend[k]   = 1'b0;
    end
  endtask

  // Called at each rising edge with the inputs the DUTs just sampled.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      obs_t o;
      bit   commit;
      int   period;
      int   d;
      int   w;
      o      = '0;
      commit = 1'b0;
      period = R + glen(k);
      if (!rst_n) begin
        m_run[k]    = 1'b0;
        m_pos[k]    = 0;
        m_shadow[k] = '0;
        m_active[k] = '0;
        m_pend[k]   = 1'b0;
      end else begin
        if (!m_run[k]) begin
          if (enable) begin
            m_run[k] = 1'b1;
            m_pos[k] = 0;
            commit   = 1'b1;
          end
        end else begin
          m_pos[k]++;
          if (m_pos[k] == flen(k)) begin
            m_pos[k] = 0;
            o.fd     = 1'b1;
            commit   = 1'b1;
            if (!enable) m_run[k] = 1'b0;
          end
        end
        if (load) begin
          m_shadow[k] = value;
          m_pend[k]   = 1'b1;
        end
        if (commit) begin
          if (load) begin
            m_active[k] = value;
            m_pend[k]   = 1'b0;
          end else if (m_pend[k]) begin
            m_active[k] = m_shadow[k];
            m_pend[k]   = 1'b0;
          end
        end
        if (m_run[k]) begin
          d = m_pos[k] / period;
          w = m_pos[k] % period;
          if (w < R && !blank_mask[d]) begin
            o.de = 4'b0001 << d;
            o.sg = seg_tab[m_active[k][4*d +: 4]];
          end
        end
      end
      if (k == 0) exp_q0.push_back(o);
      else exp_q1.push_back(o);
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got de=%b seg=%b fd=%b, required de=%b seg=%b fd=%b",
               name, $time, act.de, act.sg, act.fd, exp.de, exp.sg, exp.fd);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle both DUTs present an output word; compare against the oldest prediction.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      a.de = de_g1;
      a.sg = sg_g1;
      a.fd = fd_g1;
      check_obs("stream_guard1", a, e);
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      a.de = de_g0;
      a.sg = sg_g0;
      a.fd = fd_g0;
      check_obs("stream_guard0", a, e);
    end
  end

  // Inputs are applied 1 time unit after an edge and held through the next edge.
  task automatic cyc(input bit en, input bit ld, input logic [15:0] v, input logic [3:0] bm);
    enable     = en;
    load       = ld;
    value      = v;
    blank_mask = bm;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_until_pos(input int k, input int target, input bit en, input logic [3:0] bm);
    int i;
    i = 0;
    while (!(m_run[k] && m_pos[k] == target) && i < 200) begin
      cyc(en, 1'b0, 16'h0, bm);
      i++;
    end
    check_val("reach_frame_position", {31'd0, (m_run[k] && m_pos[k] == target)}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          en_r;
    bit          ld_r;
    logic [3:0]  bm_r;

    model_reset();
    rst_n = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 4'h0);
    check_val("reset_digit_en", {28'd0, de_g1}, 32'd0);
    check_val("reset_seg", {25'd0, sg_g1}, 32'd0);
    rst_n = 1'b1;

    // Load first, then start scanning: first digit is the low nibble 4.
    cyc(1'b0, 1'b1, 16'h1234, 4'h0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0);
    check_val("first_drive_en", {28'd0, de_g1}, 32'h1);
    check_val("first_drive_seg", {25'd0, sg_g1}, 32'h33);

    // Mid-frame load during digit 1 must not tear the running frame.
    run_until_pos(0, 6, 1'b1, 4'h0);
    cyc(1'b1, 1'b1, 16'hABCD, 4'h0);
    run_until_pos(0, 10, 1'b1, 4'h0);
    check_val("no_tear_digit2", {25'd0, sg_g1}, 32'h6D);
    run_until_pos(0, 19, 1'b1, 4'h0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0);
    check_val("new_frame_seg_D", {25'd0, sg_g1}, 32'h3D);
    check_val("new_frame_done", {31'd0, fd_g1}, 32'd1);

    // Load exactly on the frame-end edge goes straight to display.
    run_until_pos(0, 19, 1'b1, 4'h0);
    cyc(1'b1, 1'b1, 16'hFFFF, 4'h0);
    check_val("frame_end_load_seg_F", {25'd0, sg_g1}, 32'h47);

    // Blank digits 0 and 2 for a frame.
    run_until_pos(0, 19, 1'b1, 4'h0);
    cyc(1'b1, 1'b0, 16'h0, 4'b0101);
    check_val("blank_digit0_en", {28'd0, de_g1}, 32'd0);
    run_until_pos(0, 5, 1'b1, 4'b0101);
    check_val("unblanked_digit1_en", {28'd0, de_g1}, 32'h2);
    run_until_pos(0, 19, 1'b1, 4'b0101);

    // Drop enable during digit 2: frame completes, then idle; re-enable restarts at digit 0.
    run_until_pos(0, 11, 1'b1, 4'h0);
    repeat (30) cyc(1'b0, 1'b0, 16'h0, 4'h0);
    check_val("idle_digit_en", {28'd0, de_g1}, 32'd0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0);
    check_val("restart_digit0", {28'd0, de_g1}, 32'h1);

    // Randomized traffic against the model.
    en_r = 1'b1;
    bm_r = 4'h0;
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      if ($urandom_range(0, 15) == 0) bm_r = 4'($urandom);
      ld_r = ($urandom_range(0, 7) == 0);
      // Keep loads off the edge that starts scanning from idle.
      if (en_r && (!m_run[0] || !m_run[1])) ld_r = 1'b0;
      cyc(en_r, ld_r, 16'($urandom), bm_r);
    end

    // Asynchronous reset in the middle of digit 1 of the no-guard instance.
    run_until_pos(1, 5, 1'b1, 4'h0);
    check_val("pre_reset_drive_en", {28'd0, de_g0}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_en", {28'd0, de_g0}, 32'd0);
    check_val("async_reset_seg", {25'd0, sg_g0}, 32'd0);
    check_val("async_reset_fd", {31'd0, fd_g0}, 32'd0);
    check_val("async_reset_en_g1", {28'd0, de_g1}, 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    model_reset();
    repeat (2) cyc(1'b0, 1'b0, 16'h0, 4'h0);
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 16'h0, 4'h0);
    check_val("post_reset_en", {28'd0, de_g0}, 32'h1);
    check_val("post_reset_seg_0", {25'd0, sg_g0}, 32'h7E);
    repeat (40) cyc(1'b1, 1'b0, 16'h0, 4'h0);
    repeat (25) cyc(1'b0, 1'b0, 16'h0, 4'h0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
